atm_ctrl_param: RTL and testbench

ATM_CTRL_PARAM -- requirements
Module: atm_ctrl_param

---
 rtl/atm_ctrl_param.sv | 245 ++++++++++++++++++++++++
 tb/tb_atm_ctrl_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_ctrl_param.sv
// ---------------------------------------------------------------------------
// atm_ctrl_param -- ATM session controller.
//
// Walks a card session through PIN entry, menu, deposit, withdraw and balance
// display. The account balance persists across sessions; only rst restores
// INIT_BAL.
//
// Optional feature macro: ATM_TIMEOUT_EN
//   defined   : an idle counter aborts user-wait states after TIMEOUT_CYC
//               idle cycles (-> removeCard, one-cycle timeoutFlag pulse).
//   undefined : no idle counter, timeoutFlag is constant 0.
//
// Parameters: BAL_W (balance/amount width), MAX_TRIES (wrong-PIN limit),
//             TIMEOUT_CYC (idle cycles before abort), INIT_BAL (reset balance)
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   insertCard          : card inserted
//   cardRemoved         : card taken by the user
//   cancelAction        : user cancel
//   passwordEntered     : PIN submitted; correctPassword qualifies it
//   optionSelect[1:0]   : 1=withdraw 2=deposit 3=balance 0=none
//   moneyInserted       : deposit accepted, depositAmount holds the value
//   amountEntered       : withdraw request, withdrawAmount holds the value
//   moneyTaken          : dispensed cash removed
//   state[3:0]          : registered state code
//   balance[BAL_W-1:0]  : registered account balance
//   triesLeft[2:0]      : remaining PIN attempts
//   cardRetained        : high for the single cycle spent in retainCard
//   timeoutFlag         : high for one cycle after an idle timeout
// ---------------------------------------------------------------------------
module atm_ctrl_param #(
    parameter int unsigned BAL_W       = 16,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned INIT_BAL    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             insertCard,
    input  logic             cardRemoved,
    input  logic             cancelAction,
    input  logic             passwordEntered,
    input  logic             correctPassword,
    input  logic [1:0]       optionSelect,
    input  logic             moneyInserted,
    input  logic [BAL_W-1:0] depositAmount,
    input  logic             amountEntered,
    input  logic [BAL_W-1:0] withdrawAmount,
    input  logic             moneyTaken,
    output logic [3:0]       state,
    output logic [BAL_W-1:0] balance,
    output logic [2:0]       triesLeft,
    output logic             cardRetained,
    output logic             timeoutFlag
);

    localparam int unsigned TRIES_W = 3;

    typedef enum logic [3:0] {
        ST_WELCOME   = 4'd0,
        ST_ENTER_PW  = 4'd1,
        ST_REMOVE    = 4'd2,
        ST_OPTION    = 4'd3,
        ST_PUT_MONEY = 4'd4,
        ST_SHOW_BAL  = 4'd5,
        ST_ENTER_AMT = 4'd6,
        ST_CHECK_BAL = 4'd7,
        ST_NO_BAL    = 4'd8,
        ST_GIVE      = 4'd9,
        ST_RECEIPT   = 4'd10,
        ST_RETAIN    = 4'd11
    } state_t;

    state_t                 state_q,    state_d;
    logic [BAL_W-1:0]       balance_q,  balance_d;
    logic [BAL_W-1:0]       amount_q,   amount_d;
    logic [TRIES_W-1:0]     tries_q,    tries_d;
    logic                   card_ret_q, card_ret_d;
    logic [BAL_W:0]         dep_sum;
    logic [BAL_W-1:0]       dep_sat;

`ifdef ATM_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
    logic                   timeout_q,  timeout_d;
    logic                   wait_state;
    logic                   any_input;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WELCOME;
            balance_q  <= BAL_W'(INIT_BAL);
            amount_q   <= '0;
            tries_q    <= TRIES_W'(MAX_TRIES);
            card_ret_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            balance_q  <= balance_d;
            amount_q   <= amount_d;
            tries_q    <= tries_d;
            card_ret_q <= card_ret_d;
        end
    end

`ifdef ATM_TIMEOUT_EN
    // Idle counter and timeout pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
`endif

    // Next-state and datapath logic
    always_comb begin
        state_d    = state_q;
        balance_d  = balance_q;
        amount_d   = amount_q;
        tries_d    = tries_q;
        card_ret_d = 1'b0;
        // Deposit saturates at all-ones instead of wrapping
        dep_sum    = {1'b0, balance_q} + {1'b0, depositAmount};
        dep_sat    = dep_sum[BAL_W] ? {BAL_W{1'b1}} : dep_sum[BAL_W-1:0];
`ifdef ATM_TIMEOUT_EN
        idle_cnt_d = '0;
        timeout_d  = 1'b0;
        wait_state = 1'b0;
        any_input  = insertCard | cardRemoved | cancelAction | passwordEntered |
                     correctPassword | (optionSelect != 2'd0) | moneyInserted |
                     amountEntered | moneyTaken;
`endif

        case (state_q)
            ST_WELCOME: begin
                if (insertCard) begin
                    state_d = ST_ENTER_PW;
                    tries_d = TRIES_W'(MAX_TRIES);
                end
            end
            ST_ENTER_PW: begin
                if (cancelAction) begin
                    state_d = ST_REMOVE;
                end else if (passwordEntered) begin
                    if (correctPassword) begin
                        state_d = ST_OPTION;
                    end else if (tries_q <= TRIES_W'(1)) begin
                        tries_d = '0;
                        state_d = ST_RETAIN;
                    end else begin
                        tries_d = tries_q - TRIES_W'(1);
                    end
                end
            end
            ST_REMOVE: begin
                if (cardRemoved) begin
                    state_d = ST_WELCOME;
                end
            end
            ST_OPTION: begin
                if (cancelAction) begin
                    state_d = ST_REMOVE;
                end else begin
                    case (optionSelect)
                        2'd1:    state_d = ST_ENTER_AMT;
                        2'd2:    state_d = ST_PUT_MONEY;
                        2'd3:    state_d = ST_SHOW_BAL;
                        default: state_d = ST_OPTION;
                    endcase
                end
            end
            ST_PUT_MONEY: begin
                if (cancelAction) begin
                    state_d = ST_REMOVE;
                end else if (moneyInserted) begin
                    balance_d = dep_sat;
                    state_d   = ST_SHOW_BAL;
                end
            end
            ST_SHOW_BAL:  state_d = ST_RECEIPT;
            ST_RECEIPT:   state_d = ST_OPTION;
            ST_ENTER_AMT: begin
                if (cancelAction) begin
                    state_d = ST_REMOVE;
                end else if (amountEntered) begin
                    amount_d = withdrawAmount;
                    state_d  = ST_CHECK_BAL;
                end
            end
            ST_CHECK_BAL: begin
                if (amount_q <= balance_q) begin
                    balance_d = balance_q - amount_q;
                    state_d   = ST_GIVE;
                end else begin
                    state_d = ST_NO_BAL;
                end
            end
            ST_NO_BAL:    state_d = ST_ENTER_AMT;
            ST_GIVE: begin
                if (moneyTaken) begin
                    state_d = ST_RECEIPT;
                end
            end
            ST_RETAIN:    state_d = ST_WELCOME;
            default:      state_d = ST_WELCOME;
        endcase

`ifdef ATM_TIMEOUT_EN
        // Wait states never move without an input, so an idle cycle here
        // implies the state is unchanged and the count may advance.
        wait_state = (state_q == ST_ENTER_PW)  || (state_q == ST_OPTION) ||
                     (state_q == ST_PUT_MONEY) || (state_q == ST_ENTER_AMT) ||
                     (state_q == ST_GIVE);
        if (wait_state && !any_input) begin
            if (idle_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                state_d   = ST_REMOVE;
                timeout_d = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
        end
`endif

        // retainCard lasts exactly one cycle, so this is a one-cycle pulse
        card_ret_d = (state_d == ST_RETAIN);
    end

    assign state        = state_q;
    assign balance      = balance_q;
    assign triesLeft    = tries_q;
    assign cardRetained = card_ret_q;
`ifdef ATM_TIMEOUT_EN
    assign timeoutFlag  = timeout_q;
`else
    // TIMEOUT_CYC is at least 1, so this is constant 0
    assign timeoutFlag  = (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_atm_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_atm_ctrl_param -- self-checking bench for atm_ctrl_param.
// A behavioural session model runs alongside the DUT and is compared every
// cycle; directed sequences additionally pin literal expected values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_atm_ctrl_param;

    localparam int unsigned BAL_W   = 8;
    localparam int          MAXB    = 255;
    localparam int          TRIES   = 3;
    localparam int          TO_CYC  = 5;
    localparam int          INIT_B  = 0;

    logic             clk = 1'b0;
    logic             rst;
    logic             insertCard, cardRemoved, cancelAction;
    logic             passwordEntered, correctPassword;
    logic [1:0]       optionSelect;
    logic             moneyInserted, amountEntered, moneyTaken;
    logic [BAL_W-1:0] depositAmount, withdrawAmount;
    logic [3:0]       state;
    logic [BAL_W-1:0] balance;
    logic [2:0]       triesLeft;
    logic             cardRetained, timeoutFlag;

    int tests = 0;
    int fails = 0;

    atm_ctrl_param #(
        .BAL_W(BAL_W), .MAX_TRIES(TRIES), .TIMEOUT_CYC(TO_CYC), .INIT_BAL(INIT_B)
    ) dut (
        .clk(clk), .rst(rst),
        .insertCard(insertCard), .cardRemoved(cardRemoved),
        .cancelAction(cancelAction), .passwordEntered(passwordEntered),
        .correctPassword(correctPassword), .optionSelect(optionSelect),
        .moneyInserted(moneyInserted), .depositAmount(depositAmount),
        .amountEntered(amountEntered), .withdrawAmount(withdrawAmount),
        .moneyTaken(moneyTaken), .state(state), .balance(balance),
        .triesLeft(triesLeft), .cardRetained(cardRetained),
        .timeoutFlag(timeoutFlag)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_state, m_bal, m_tries, m_amt, m_idle, m_ns;
    bit m_ret, m_to, m_any, started = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_bal = INIT_B; m_tries = TRIES; m_amt = 0;
            m_idle = 0; m_ret = 0; m_to = 0;
        end else begin
            m_ns  = m_state;
            m_to  = 0;
            m_any = insertCard || cardRemoved || cancelAction || passwordEntered ||
                    correctPassword || optionSelect != 0 || moneyInserted ||
                    amountEntered || moneyTaken;
            if (cancelAction && (m_state == 1 || m_state == 3 || m_state == 4 || m_state == 6))
                m_ns = 2;
            else if (m_state == 0) begin
                if (insertCard) begin m_ns = 1; m_tries = TRIES; end
            end else if (m_state == 1) begin
                if (passwordEntered && correctPassword) m_ns = 3;
                else if (passwordEntered) begin
                    m_tries = m_tries - 1;
                    if (m_tries <= 0) begin m_tries = 0; m_ns = 11; end
                end
            end else if (m_state == 2) begin
                if (cardRemoved) m_ns = 0;
            end else if (m_state == 3) begin
                if (optionSelect == 1) m_ns = 6;
                if (optionSelect == 2) m_ns = 4;
                if (optionSelect == 3) m_ns = 5;
            end else if (m_state == 4) begin
                if (moneyInserted) begin
                    m_bal = m_bal + int'(depositAmount);
                    if (m_bal > MAXB) m_bal = MAXB;
                    m_ns = 5;
                end
            end else if (m_state == 5) m_ns = 10;
            else if (m_state == 10) m_ns = 3;
            else if (m_state == 6) begin
                if (amountEntered) begin m_amt = int'(withdrawAmount); m_ns = 7; end
            end else if (m_state == 7) begin
                if (m_amt <= m_bal) begin m_bal = m_bal - m_amt; m_ns = 9; end
                else m_ns = 8;
            end else if (m_state == 8) m_ns = 6;
            else if (m_state == 9) begin
                if (moneyTaken) m_ns = 10;
            end else m_ns = 0;
`ifdef ATM_TIMEOUT_EN
            if ((m_state == 1 || m_state == 3 || m_state == 4 || m_state == 6 ||
                 m_state == 9) && !m_any) begin
                m_idle = m_idle + 1;
                if (m_idle == TO_CYC) begin m_ns = 2; m_to = 1; m_idle = 0; end
            end else m_idle = 0;
`endif
            m_ret   = (m_ns == 11);
            m_state = m_ns;
        end
        started = 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            tests++;
            if (int'(state) !== m_state || int'(balance) !== m_bal ||
                int'(triesLeft) !== m_tries || cardRetained !== m_ret ||
                timeoutFlag !== m_to) begin
                fails++;
                $display("FAIL model_cmp t=%0t got st=%0d bal=%0d tries=%0d ret=%b to=%b exp st=%0d bal=%0d tries=%0d ret=%0d to=%0d",
                         $time, state, balance, triesLeft, cardRetained, timeoutFlag,
                         m_state, m_bal, m_tries, m_ret, m_to);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input int exp);
        tests++;
        if (got !== 32'(exp)) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic clr();
        rst = 0; insertCard = 0; cardRemoved = 0; cancelAction = 0;
        passwordEntered = 0; correctPassword = 0; optionSelect = 0;
        moneyInserted = 0; amountEntered = 0; moneyTaken = 0;
        depositAmount = 0; withdrawAmount = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic st_bal(input string nm, input int st, input int bal);
        chk({nm, "_state"}, 32'(state), st);
        chk({nm, "_bal"}, 32'(balance), bal);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr();
        rst = 1; tick();
        st_bal("reset", 0, 0);
        chk("reset_tries", 32'(triesLeft), 3);
        chk("reset_ret", 32'(cardRetained), 0);
        chk("reset_to", 32'(timeoutFlag), 0);

        // Card retained after three wrong PINs
        insertCard = 1; tick(); chk("ins_state", 32'(state), 1); chk("ins_tries", 32'(triesLeft), 3);
        passwordEntered = 1; tick(); chk("pw1_state", 32'(state), 1); chk("pw1_tries", 32'(triesLeft), 2);
        passwordEntered = 1; tick(); chk("pw2_state", 32'(state), 1); chk("pw2_tries", 32'(triesLeft), 1);
        passwordEntered = 1; tick(); chk("pw3_state", 32'(state), 11); chk("pw3_tries", 32'(triesLeft), 0);
        chk("pw3_ret", 32'(cardRetained), 1);
        tick(); chk("ret_exit", 32'(state), 0); chk("ret_clear", 32'(cardRetained), 0);

        // Deposit 100
        insertCard = 1; tick(); chk("s2_ins", 32'(state), 1);
        passwordEntered = 1; correctPassword = 1; tick(); chk("s2_pw", 32'(state), 3);
        optionSelect = 2; tick(); chk("s2_opt", 32'(state), 4);
        moneyInserted = 1; depositAmount = 100; tick(); st_bal("dep100", 5, 100);
        tick(); chk("dep_rcpt", 32'(state), 10);
        tick(); st_bal("dep_opt", 3, 100);

        // Withdraw 150 refused, then 40 granted
        optionSelect = 1; tick(); chk("wd_amt", 32'(state), 6);
        amountEntered = 1; withdrawAmount = 150; tick(); chk("wd150_chk", 32'(state), 7);
        tick(); st_bal("wd150_nobal", 8, 100);
        tick(); chk("wd150_back", 32'(state), 6);
        amountEntered = 1; withdrawAmount = 40; tick(); chk("wd40_chk", 32'(state), 7);
        tick(); st_bal("wd40_give", 9, 60);
        moneyTaken = 1; tick(); chk("wd40_rcpt", 32'(state), 10);
        tick(); st_bal("wd40_opt", 3, 60);

        // Saturation at 255
        optionSelect = 2; tick();
        moneyInserted = 1; depositAmount = 190; tick(); st_bal("dep190", 5, 250);
        tick(); tick();
        optionSelect = 2; tick();
        moneyInserted = 1; depositAmount = 10; tick(); st_bal("sat", 5, 255);
        tick(); tick(); chk("sat_opt", 32'(state), 3);

        // Cancel beats amountEntered; reset mid-dispense
        optionSelect = 1; tick();
        cancelAction = 1; amountEntered = 1; withdrawAmount = 5; tick(); st_bal("cancel", 2, 255);
        cardRemoved = 1; tick(); chk("removed", 32'(state), 0);
        insertCard = 1; tick();
        passwordEntered = 1; correctPassword = 1; tick();
        optionSelect = 1; tick();
        amountEntered = 1; withdrawAmount = 55; tick();
        tick(); st_bal("give", 9, 200);
        rst = 1; moneyTaken = 1; tick(); st_bal("rst_give", 0, 0);
        chk("rst_tries", 32'(triesLeft), 3);

        // Idle in optionScreen
        insertCard = 1; tick();
        passwordEntered = 1; correctPassword = 1; tick(); chk("idle_start", 32'(state), 3);
        for (int i = 0; i < 4; i++) tick();
        chk("idle_4", 32'(state), 3);
        tick();
`ifdef ATM_TIMEOUT_EN
        chk("idle_5_state", 32'(state), 2); chk("idle_5_flag", 32'(timeoutFlag), 1);
        tick(); chk("to_pulse_end", 32'(timeoutFlag), 0);
`else
        chk("idle_5_state", 32'(state), 3); chk("idle_5_flag", 32'(timeoutFlag), 0);
        cancelAction = 1; tick(); chk("idle_cancel", 32'(state), 2);
`endif
        cardRemoved = 1; tick(); chk("idle_home", 32'(state), 0);

        // Randomized sessions against the model
        for (int c = 0; c < 4000; c++) begin
            rst             = ($urandom_range(0, 299) == 0);
            insertCard      = ($urandom_range(0, 1) == 0);
            cardRemoved     = ($urandom_range(0, 2) == 0);
            cancelAction    = ($urandom_range(0, 19) == 0);
            passwordEntered = ($urandom_range(0, 2) == 0);
            correctPassword = ($urandom_range(0, 3) != 0);
            optionSelect    = ($urandom_range(0, 1) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            moneyInserted   = ($urandom_range(0, 2) == 0);
            depositAmount   = BAL_W'($urandom);
            amountEntered   = ($urandom_range(0, 2) == 0);
            withdrawAmount  = ($urandom_range(0, 4) == 0) ? '0 : BAL_W'($urandom);
            moneyTaken      = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) begin
                insertCard = 0; cardRemoved = 0; cancelAction = 0; passwordEntered = 0;
                correctPassword = 0; optionSelect = 0; moneyInserted = 0;
                amountEntered = 0; moneyTaken = 0; rst = 0;
            end
            tick();
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
